// File: rtl/wfifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wfifo_wr_arbiter
// Desc     : Round-robin, burst-limited arbiter for the async FIFO write port.
// Revision : 1.0 - initial release
// ============================================================================
module wfifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int IDLE_TO   = 8
) (
  input  logic                       wclk,
  input  logic                       wrst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       wfull,
  output logic                       winc,
  output logic [DATA_W-1:0]          wdata,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int c_GID_W  = $clog2(NUM_REQ);
  localparam int c_BEAT_W = $clog2(MAX_BURST + 1);
  localparam int c_IDLE_W = $clog2(IDLE_TO + 1);
  localparam logic [c_BEAT_W-1:0] c_BEAT_END = c_BEAT_W'(MAX_BURST - 1);
  localparam logic [c_IDLE_W-1:0] c_IDLE_END = c_IDLE_W'(IDLE_TO - 1);
  localparam logic [c_GID_W-1:0]  c_GID_MAX  = c_GID_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t              r_state;
  logic [c_GID_W-1:0]  r_rr_ptr;
  logic [c_GID_W-1:0]  r_grant_id;
  logic [c_BEAT_W-1:0] r_beat_cnt;
  logic [c_IDLE_W-1:0] r_idle_cnt;

  logic [DATA_W-1:0]   w_slice [NUM_REQ];
  logic                w_any;
  logic [c_GID_W-1:0]  w_sel;
  logic                w_busy;
  logic                w_beat;
  logic                w_release;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign w_slice[i] = req_data[i*DATA_W +: DATA_W];
  end

  // Scan from the farthest offset down so the entry closest to r_rr_ptr wins.
  always_comb begin
    int idx;
    idx   = 0;
    w_any = 1'b0;
    w_sel = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        w_any = 1'b1;
        w_sel = idx[c_GID_W-1:0];
      end
    end
  end

  assign w_busy    = (r_state == S_GRANT);
  assign w_beat    = w_busy & req_valid[r_grant_id] & ~wfull;
  assign w_release = w_beat ? (req_last[r_grant_id] | (r_beat_cnt == c_BEAT_END))
                            : (r_idle_cnt == c_IDLE_END);

  assign winc     = w_beat;
  assign wdata    = w_beat ? w_slice[r_grant_id] : '0;
  assign busy     = w_busy;
  assign grant_id = r_grant_id;

  always_comb begin
    req_ready = '0;
    if (w_busy && !wfull) begin
      req_ready[r_grant_id] = 1'b1;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
      r_idle_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant_id <= w_sel;
            r_beat_cnt <= '0;
            r_idle_cnt <= '0;
            r_state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= (r_grant_id == c_GID_MAX) ? '0 : r_grant_id + 1'b1;
            r_beat_cnt <= '0;
            r_idle_cnt <= '0;
          end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            r_idle_cnt <= '0;
          end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wfifo_wr_arbiter.sv
`default_nettype none
// Testbench for wfifo_wr_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level arbitration model.
module tb_wfifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;
  localparam int IDLE_TO   = 8;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        wfull;
  logic        winc;
  logic [7:0]  wdata;
  logic [1:0]  grant_id;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: owner is -1 between grants.
  int   m_owner, m_gid, m_rr, m_beats, m_quiet;
  logic [3:0] e_ready;
  logic       e_winc, e_busy;
  logic [7:0] e_wdata;
  logic [1:0] e_gid;

  wfifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .IDLE_TO(IDLE_TO)
  ) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .wfull(wfull), .winc(winc),
    .wdata(wdata), .grant_id(grant_id), .busy(busy)
  );

  always #5 wclk = ~wclk;

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic apply_reset();
    wrst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0; wfull = 1'b0;
    tick();
    tick();
    wrst_n = 1'b1;
  endtask

  function automatic void model_reset();
    m_owner = -1; m_gid = 0; m_rr = 0; m_beats = 0; m_quiet = 0;
  endfunction

  function automatic void model_comb();
    e_ready = '0; e_winc = 1'b0; e_wdata = '0;
    e_busy  = (m_owner >= 0);
    e_gid   = 2'(m_gid);
    if (m_owner >= 0 && !wfull) begin
      e_ready[m_owner] = 1'b1;
      if (req_valid[m_owner]) begin
        e_winc  = 1'b1;
        e_wdata = req_data[m_owner*8 +: 8];
      end
    end
  endfunction

  function automatic void model_clock();
    bit found;
    int cand;
    found = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = (m_rr + k) % NUM_REQ;
        if (!found && req_valid[cand]) begin
          found = 1'b1; m_owner = cand; m_gid = cand; m_beats = 0; m_quiet = 0;
        end
      end
    end else if (req_valid[m_owner] && !wfull) begin
      m_beats++;
      m_quiet = 0;
      if (req_last[m_owner] || m_beats == MAX_BURST) begin
        m_rr = (m_owner + 1) % NUM_REQ; m_owner = -1;
      end
    end else begin
      m_quiet++;
      if (m_quiet == IDLE_TO) begin
        m_rr = (m_owner + 1) % NUM_REQ; m_owner = -1;
      end
    end
  endfunction

  task automatic test_reset();
    wrst_n = 1'b0; req_valid = 4'hF; req_last = 4'hF; req_data = 32'hA5A5_A5A5; wfull = 1'b0;
    tick();
    #4;
    n_vec++;
    if ({busy, winc, req_ready, grant_id, wdata} !== 16'h0) begin
      n_err++; $display("FAIL reset_idle: got %h expected 0000", {busy, winc, req_ready, grant_id, wdata});
    end
    tick();
    wrst_n = 1'b1; req_data = '0; req_data[23:16] = 8'hC2; req_valid = 4'b0100; req_last = 4'b0100;
    tick();
    #4;
    n_vec++;
    if (winc !== 1'b1 || wdata !== 8'hC2) begin
      n_err++; $display("FAIL reset_first_beat: got winc=%b wdata=%h expected 1 c2", winc, wdata);
    end
    tick();
    req_data[23:16] = 8'hC3; req_last = 4'b0000; wfull = 1'b1;
    tick();
    #4;
    n_vec++;
    if (busy !== 1'b1 || grant_id !== 2'd2 || winc !== 1'b0) begin
      n_err++; $display("FAIL reset_pre_grant: got busy=%b gid=%0d winc=%b expected 1 2 0", busy, grant_id, winc);
    end
    wfull = 1'b0;
    #1;
    n_vec++;
    if (winc !== 1'b1 || wdata !== 8'hC3 || req_ready !== 4'b0100) begin
      n_err++; $display("FAIL reset_pre_beat: got winc=%b wdata=%h rdy=%b expected 1 c3 0100", winc, wdata, req_ready);
    end
    wrst_n = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || winc !== 1'b0 || req_ready !== 4'b0000) begin
      n_err++; $display("FAIL reset_async: got busy=%b winc=%b rdy=%b expected 0 0 0000", busy, winc, req_ready);
    end
    tick();
    req_valid = 4'b1010; req_last = '0; wrst_n = 1'b1;
    tick();
    #4;
    n_vec++;
    if (busy !== 1'b1 || grant_id !== 2'd1) begin
      n_err++; $display("FAIL reset_rr_ptr: got busy=%b gid=%0d expected 1 1", busy, grant_id);
    end
    tick();
  endtask

  task automatic test_round_robin();
    bit e_w;
    int e_g;
    apply_reset();
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'h10 + 8'(i);
    req_valid = 4'hF; req_last = '0; wfull = 1'b0;
    for (int c = 0; c < 25; c++) begin
      #4;
      e_w = (c % 5) != 0;
      e_g = (c / 5) % 4;
      n_vec++;
      if (winc !== e_w) begin
        n_err++; $display("FAIL rr_winc c=%0d: got %b expected %b", c, winc, e_w);
      end
      if (e_w) begin
        n_vec++;
        if (grant_id !== 2'(e_g) || wdata !== 8'h10 + 8'(e_g)) begin
          n_err++; $display("FAIL rr_grant c=%0d: got gid=%0d wdata=%h expected %0d %h", c, grant_id, wdata, e_g, 8'h10 + 8'(e_g));
        end
      end
      tick();
    end
  endtask

  task automatic test_last_release();
    logic       x_busy [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] x_wd   [5] = '{8'h00, 8'hA1, 8'hA2, 8'h00, 8'h33};
    logic [1:0] x_gid  [5] = '{2'd0, 2'd2, 2'd2, 2'd0, 2'd3};
    apply_reset();
    req_data[23:16] = 8'hA1; req_data[31:24] = 8'h33;
    req_valid = 4'b1100; req_last = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      #4;
      n_vec++;
      if (busy !== x_busy[c] || winc !== x_busy[c] || wdata !== x_wd[c]) begin
        n_err++; $display("FAIL last_beat c=%0d: got busy=%b winc=%b wdata=%h expected %b %b %h", c, busy, winc, wdata, x_busy[c], x_busy[c], x_wd[c]);
      end
      if (x_busy[c]) begin
        n_vec++;
        if (grant_id !== x_gid[c]) begin
          n_err++; $display("FAIL last_gid c=%0d: got %0d expected %0d", c, grant_id, x_gid[c]);
        end
      end
      tick();
      if (c == 1) begin req_data[23:16] = 8'hA2; req_last[2] = 1'b1; end
      if (c == 2) begin req_valid[2] = 1'b0; req_last[2] = 1'b0; end
      if (c == 4) req_valid[3] = 1'b0;
    end
  endtask

  task automatic test_wfull();
    logic [7:0] got [$];
    int  idx;
    bit  acc;
    apply_reset();
    idx = 0;
    req_data[7:0] = 8'h50; req_valid = 4'b0001;
    for (int c = 0; c < 9; c++) begin
      wfull = (c >= 2 && c <= 4);
      #4;
      if (wfull) begin
        n_vec++;
        if (winc !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1) begin
          n_err++; $display("FAIL wfull_stall c=%0d: got winc=%b rdy=%b busy=%b expected 0 0000 1", c, winc, req_ready, busy);
        end
      end
      acc = req_valid[0] && req_ready[0];
      if (winc) got.push_back(wdata);
      tick();
      if (acc) begin
        idx++;
        req_data[7:0] = 8'h50 + 8'(idx);
        if (idx == 4) req_valid = '0;
      end
    end
    n_vec++;
    if (got.size() != 4) begin
      n_err++; $display("FAIL wfull_count: got %0d beats expected 4", got.size());
    end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      n_vec++;
      if (got[i] !== 8'h50 + 8'(i)) begin
        n_err++; $display("FAIL wfull_order i=%0d: got %h expected %h", i, got[i], 8'h50 + 8'(i));
      end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    req_data[15:8] = 8'h61; req_data[7:0] = 8'h60; req_data[23:16] = 8'h62;
    req_valid = 4'b0010;
    for (int c = 0; c < 12; c++) begin
      #4;
      if (c == 1) begin
        n_vec++;
        if (winc !== 1'b1 || grant_id !== 2'd1 || wdata !== 8'h61) begin
          n_err++; $display("FAIL to_beat: got winc=%b gid=%0d wdata=%h expected 1 1 61", winc, grant_id, wdata);
        end
      end else if (c >= 2 && c <= 9) begin
        n_vec++;
        if (busy !== 1'b1 || grant_id !== 2'd1 || winc !== 1'b0 || req_ready !== 4'b0010) begin
          n_err++; $display("FAIL to_hold c=%0d: got busy=%b gid=%0d winc=%b rdy=%b expected 1 1 0 0010", c, busy, grant_id, winc, req_ready);
        end
      end else if (c == 10) begin
        n_vec++;
        if (busy !== 1'b0) begin
          n_err++; $display("FAIL to_release: got busy=%b expected 0", busy);
        end
      end else if (c == 11) begin
        n_vec++;
        if (busy !== 1'b1 || grant_id !== 2'd2) begin
          n_err++; $display("FAIL to_next: got busy=%b gid=%0d expected 1 2", busy, grant_id);
        end
      end
      tick();
      if (c == 1) req_valid = 4'b0101;
    end
    req_valid = '0;
  endtask

  task automatic test_wrap();
    apply_reset();
    req_data[31:24] = 8'h73; req_data[7:0] = 8'h70;
    req_valid = 4'b1000; req_last = 4'b1000;
    for (int c = 0; c < 4; c++) begin
      #4;
      if (c == 1) begin
        n_vec++;
        if (winc !== 1'b1 || grant_id !== 2'd3) begin
          n_err++; $display("FAIL wrap_g3: got winc=%b gid=%0d expected 1 3", winc, grant_id);
        end
      end else if (c == 2) begin
        n_vec++;
        if (busy !== 1'b0) begin
          n_err++; $display("FAIL wrap_gap: got busy=%b expected 0", busy);
        end
      end else if (c == 3) begin
        n_vec++;
        if (grant_id !== 2'd0 || winc !== 1'b1 || wdata !== 8'h70) begin
          n_err++; $display("FAIL wrap_g0: got gid=%0d winc=%b wdata=%h expected 0 1 70", grant_id, winc, wdata);
        end
      end
      tick();
      if (c == 1) begin req_data[31:24] = 8'h74; req_valid = 4'b1001; end
    end
  endtask

  task automatic test_random();
    logic [3:0] acc;
    int pct;
    apply_reset();
    model_reset();
    acc = '0;
    for (int c = 0; c < 1500; c++) begin
      pct = (c < 750) ? 70 : 20;
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i] || acc[i]) begin
          if (int'($urandom_range(99)) < pct) begin
            req_valid[i] = 1'b1;
            req_data[i*8 +: 8] = 8'($urandom);
            req_last[i] = ($urandom_range(3) == 0);
          end else begin
            req_valid[i] = 1'b0;
            req_last[i] = 1'b0;
          end
        end
      end
      wfull = ($urandom_range(3) == 0);
      #4;
      model_comb();
      n_vec++;
      if (busy !== e_busy || grant_id !== e_gid) begin
        n_err++; $display("FAIL rnd_grant c=%0d: got busy=%b gid=%0d expected %b %0d", c, busy, grant_id, e_busy, e_gid);
      end
      n_vec++;
      if (winc !== e_winc || wdata !== e_wdata) begin
        n_err++; $display("FAIL rnd_write c=%0d: got winc=%b wdata=%h expected %b %h", c, winc, wdata, e_winc, e_wdata);
      end
      n_vec++;
      if (req_ready !== e_ready) begin
        n_err++; $display("FAIL rnd_ready c=%0d: got %b expected %b", c, req_ready, e_ready);
      end
      acc = req_valid & req_ready;
      model_clock();
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_last_release();
    test_wfull();
    test_timeout();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
